// File: rtl/dlf_kcnt.sv
// K-counter loop filter for the DPLL: accumulates lead/lag decisions and issues
// one-cycle add/sub pulses to the DCO when the count reaches a loadable modulus.
module dlf_kcnt #(
  parameter int KW        = 8,
  parameter int K_DEFAULT = 16,
  parameter int MODE      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 clr,
  input  logic                 k_load,
  input  logic [KW-1:0]        k_val,
  output logic                 add,
  output logic                 sub,
  output logic signed [KW:0]   level
);

  localparam logic [KW-1:0] K_RST = KW'(K_DEFAULT);
  localparam logic [KW-1:0] UONE  = KW'(1);

  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] kmax;
  logic          flush;
  logic          add_q, add_d;
  logic          sub_q, sub_d;

  // A zero modulus would never terminate, so it is promoted to 1.
  always_comb begin
    k_d = k_q;
    if (k_load) k_d = (k_val == '0) ? UONE : k_val;
  end

  assign kmax  = k_q - UONE;
  assign flush = k_load | clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= K_RST;
      add_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      add_q <= add_d;
      sub_q <= sub_d;
    end
  end

  assign add = add_q;
  assign sub = sub_q;

  generate
    if (MODE == 0) begin : g_bidir
      localparam logic signed [KW:0] SONE = (KW+1)'(1);
      logic signed [KW:0] cnt_q, cnt_d;
      logic signed [KW:0] pos_lim, neg_lim;

      assign pos_lim = $signed({1'b0, kmax});
      assign neg_lim = -pos_lim;

      // Lead and lag share one counter, so opposing decisions cancel.
      always_comb begin
        cnt_d = cnt_q;
        add_d = 1'b0;
        sub_d = 1'b0;
        if (flush) begin
          cnt_d = '0;
        end else if (en) begin
          if (dir) begin
            if (cnt_q == pos_lim) begin
              cnt_d = '0;
              add_d = 1'b1;
            end else begin
              cnt_d = cnt_q + SONE;
            end
          end else begin
            if (cnt_q == neg_lim) begin
              cnt_d = '0;
              sub_d = 1'b1;
            end else begin
              cnt_d = cnt_q - SONE;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign level = cnt_q;
    end else begin : g_dual
      logic [KW-1:0] up_q, up_d;
      logic [KW-1:0] dn_q, dn_d;

      // Independent up and down counters; each only advances on its own direction.
      always_comb begin
        up_d  = up_q;
        dn_d  = dn_q;
        add_d = 1'b0;
        sub_d = 1'b0;
        if (flush) begin
          up_d = '0;
          dn_d = '0;
        end else if (en) begin
          if (dir) begin
            if (up_q == kmax) begin
              up_d  = '0;
              add_d = 1'b1;
            end else begin
              up_d = up_q + UONE;
            end
          end else begin
            if (dn_q == kmax) begin
              dn_d  = '0;
              sub_d = 1'b1;
            end else begin
              dn_d = dn_q + UONE;
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          up_q <= '0;
          dn_q <= '0;
        end else begin
          up_q <= up_d;
          dn_q <= dn_d;
        end
      end

      assign level = $signed({1'b0, up_q}) - $signed({1'b0, dn_q});
    end
  endgenerate

endmodule

// File: tb/tb_dlf_kcnt.sv
// Bench for dlf_kcnt: drives both counter modes with the same stimulus and
// compares add/sub/level every cycle against a modulo-arithmetic reference.
module tb_dlf_kcnt;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, dir = 1'b0, clr = 1'b0, k_load = 1'b0;
  logic [7:0] k_val = 8'd0;
  logic add0, sub0, add1, sub1;
  logic signed [8:0] level0, level1;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state, mode 0 then mode 1
  int m0_k, m0_cnt, m0_add, m0_sub;
  int m1_k, m1_up, m1_dn, m1_add, m1_sub;
  int pulses_add, pulses_sub;

  always #5 clk = ~clk;

  dlf_kcnt #(.KW(8), .K_DEFAULT(16), .MODE(0)) u_bi (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .k_load(k_load),
    .k_val(k_val), .add(add0), .sub(sub0), .level(level0));

  dlf_kcnt #(.KW(8), .K_DEFAULT(16), .MODE(1)) u_ud (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .k_load(k_load),
    .k_val(k_val), .add(add1), .sub(sub1), .level(level1));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Behavioural reference: counts are residues modulo k; a pulse marks a wrap.
  task automatic model_step();
    int nk;
    if (rst) begin
      m0_k = 16; m0_cnt = 0; m0_add = 0; m0_sub = 0;
      m1_k = 16; m1_up = 0; m1_dn = 0; m1_add = 0; m1_sub = 0;
      return;
    end
    m0_add = 0; m0_sub = 0; m1_add = 0; m1_sub = 0;
    if (k_load) begin
      nk = (k_val == 0) ? 1 : int'(k_val);
      m0_k = nk; m1_k = nk;
      m0_cnt = 0; m1_up = 0; m1_dn = 0;
    end else if (clr) begin
      m0_cnt = 0; m1_up = 0; m1_dn = 0;
    end else if (en) begin
      if (dir) begin
        m0_cnt = m0_cnt + 1;
        if (m0_cnt == m0_k) begin m0_cnt = 0; m0_add = 1; end
        m1_up = (m1_up + 1) % m1_k;
        m1_add = (m1_up == 0) ? 1 : 0;
      end else begin
        m0_cnt = m0_cnt - 1;
        if (m0_cnt == -m0_k) begin m0_cnt = 0; m0_sub = 1; end
        m1_dn = (m1_dn + 1) % m1_k;
        m1_sub = (m1_dn == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic kl, input logic c,
                     input logic e, input logic d, input logic [7:0] kv);
    @(negedge clk);
    rst = r; k_load = kl; clr = c; en = e; dir = d; k_val = kv;
    @(posedge clk);
    model_step();
    #1;
    chk("bi_add",   int'(add0),   m0_add);
    chk("bi_sub",   int'(sub0),   m0_sub);
    chk("bi_level", int'(level0), m0_cnt);
    chk("ud_add",   int'(add1),   m1_add);
    chk("ud_sub",   int'(sub1),   m1_sub);
    chk("ud_level", int'(level1), m1_up - m1_dn);
    pulses_add += int'(add0);
    pulses_sub += int'(sub0);
  endtask

  initial begin
    m0_k = 16; m0_cnt = 0; m0_add = 0; m0_sub = 0;
    m1_k = 16; m1_up = 0; m1_dn = 0; m1_add = 0; m1_sub = 0;
    pulses_add = 0; pulses_sub = 0;

    // reset
    repeat (3) cyc(1, 0, 0, 0, 0, 8'd0);
    cyc(0, 0, 0, 0, 0, 8'd0);

    // default modulus 16: full run up, then full run down
    repeat (16) cyc(0, 0, 0, 1, 1, 8'd0);
    repeat (16) cyc(0, 0, 0, 1, 0, 8'd0);
    chk("bi_runs_add", pulses_add, 1);
    chk("bi_runs_sub", pulses_sub, 1);

    // fast toggle, then 20-cycle runs per direction
    for (int i = 0; i < 200; i++) cyc(0, 0, 0, 1, 1'(i % 2 == 0), 8'd0);
    pulses_add = 0; pulses_sub = 0;
    for (int r = 0; r < 4; r++)
      repeat (20) cyc(0, 0, 0, 1, 1'(r % 2 == 0), 8'd0);
    chk("bi_20run_add", pulses_add, 2);
    chk("bi_20run_sub", pulses_sub, 2);

    // K=4, alternating direction
    cyc(0, 1, 0, 0, 0, 8'd4);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 1'(i % 2 == 0), 8'd0);

    // load K=0 (treated as 1) mid-count
    cyc(0, 1, 0, 0, 0, 8'd16);
    repeat (7) cyc(0, 0, 0, 1, 1, 8'd0);
    cyc(0, 1, 0, 1, 1, 8'd0);
    repeat (6) cyc(0, 0, 0, 1, 1, 8'd0);
    repeat (4) cyc(0, 0, 0, 1, 1'($urandom_range(0, 1)), 8'd0);

    // clr alongside a terminal en step
    cyc(0, 1, 0, 0, 0, 8'd16);
    repeat (15) cyc(0, 0, 0, 1, 1, 8'd0);
    cyc(0, 0, 1, 1, 1, 8'd0);
    cyc(0, 0, 0, 0, 1, 8'd0);

    // rst wins over k_load; default modulus restored
    repeat (10) cyc(0, 0, 0, 1, 0, 8'd0);
    cyc(1, 1, 0, 1, 1, 8'd5);
    repeat (17) cyc(0, 0, 0, 1, 1, 8'd0);

    // random mix
    for (int i = 0; i < 3000; i++) begin
      logic r, kl, c, e, d;
      logic [7:0] kv;
      r  = ($urandom_range(0, 499) == 0);
      kl = ($urandom_range(0, 149) == 0);
      c  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 6 : 4));
      kv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      cyc(r, kl, c, e, d, kv);
    end

    // extremes of the modulus range
    cyc(0, 1, 0, 0, 0, 8'd255);
    repeat (300) cyc(0, 0, 0, 1, 0, 8'd0);
    cyc(0, 1, 0, 0, 0, 8'd1);
    repeat (8) cyc(0, 0, 0, 1, 1'($urandom_range(0, 1)), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
